pipeline_hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage OTTER pipeline with caches. It drives the `stall_*`/`flush_*` inputs of the F/D, D/E and E/M pipeline registers and the E-stage forwarding mux selects. It also sequences whole-pipeline freezes while an I-cache or D-cache miss is outstanding, and keeps stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: load-use and branch
// flushing, E-stage forwarding selects, cache-miss freeze FSM and perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rs1_addr_E,
  input  logic [4:0]       rs2_addr_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             memRead2_E,
  input  logic             regWrite_M,
  input  logic             regWrite_W,
  input  logic             pc_src_E,
  input  logic             imem_miss,
  input  logic             dmem_miss,
  input  logic             mem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] D_WAIT = 2'd1;
  localparam logic [1:0] I_WAIT = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       freeze;
  logic       load_use;
  logic       br_flush;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] dst_m,
    input logic       wr_w,
    input logic [4:0] dst_w
  );
    if (wr_m && (dst_m != 5'd0) && (dst_m == rs))      return 2'b10;
    else if (wr_w && (dst_w != 5'd0) && (dst_w == rs)) return 2'b01;
    else                                               return 2'b00;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // D-miss wins in IDLE since it belongs to the older instruction
  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    case (state)
      IDLE: begin
        freeze = imem_miss | dmem_miss;
        if (dmem_miss)      state_nxt = D_WAIT;
        else if (imem_miss) state_nxt = I_WAIT;
      end
      D_WAIT, I_WAIT: begin
        freeze = ~mem_ready;
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_use = memRead2_E && (rd_E != 5'd0) &&
                    ((rd_E == rs1_addr_D) || (rd_E == rs2_addr_D));

  // Freeze keeps flushes low because the pipeline registers let flush beat stall
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    br_flush = 1'b0;
    fwdA_E   = 2'b00;
    fwdB_E   = 2'b00;
    if (RST) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else begin
      fwdA_E = fwd_sel(rs1_addr_E, regWrite_M, rd_M, regWrite_W, rd_W);
      fwdB_E = fwd_sel(rs2_addr_E, regWrite_M, rd_M, regWrite_W, rd_W);
      if (freeze) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
      end else if (pc_src_E) begin
        flush_D  = 1'b1;
        flush_E  = 1'b1;
        br_flush = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_F && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed hazard/miss scenarios plus random traffic,
// compared against a behavioural model of the controller's rules.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
  logic [4:0] rd_E, rd_M, rd_W;
  logic       memRead2_E, regWrite_M, regWrite_W, pc_src_E;
  logic       imem_miss, dmem_miss, mem_ready;

  logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
  logic [1:0]  fwdA_E, fwdB_E;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s4_F, s4_D, s4_E, s4_M, f4_D, f4_E;
  logic [1:0]  fa4, fb4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_vec = 0;
  int n_err = 0;

  bit     pending;
  longint m_stall;
  longint m_flush;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .memRead2_E(memRead2_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .pc_src_E(pc_src_E), .imem_miss(imem_miss), .dmem_miss(dmem_miss),
    .mem_ready(mem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .memRead2_E(memRead2_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .pc_src_E(pc_src_E), .imem_miss(imem_miss), .dmem_miss(dmem_miss),
    .mem_ready(mem_ready),
    .stall_F(s4_F), .stall_D(s4_D), .stall_E(s4_E), .stall_M(s4_M),
    .flush_D(f4_D), .flush_E(f4_E), .fwdA_E(fa4), .fwdB_E(fb4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (regWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
    if (regWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] sat(input longint c, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return 32'((c > lim) ? lim : c);
  endfunction

  // Inputs are already driven; check outputs mid-cycle, then advance the model at the edge
  task automatic step();
    logic       frz, lu, br;
    logic [3:0] e_st;
    logic [1:0] e_fl;
    #1;
    if (RST) begin
      pending = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end
    frz  = pending ? !mem_ready : (imem_miss || dmem_miss);
    lu   = memRead2_E && rd_E != 0 && (rd_E == rs1_addr_D || rd_E == rs2_addr_D);
    br   = 1'b0;
    e_st = 4'b0000;
    e_fl = 2'b00;
    if (RST)           e_fl = 2'b11;
    else if (frz)      e_st = 4'b1111;
    else if (pc_src_E) begin e_fl = 2'b11; br = 1'b1; end
    else if (lu)       begin e_st = 4'b1100; e_fl = 2'b01; end
    check("stalls", 32'({stall_F, stall_D, stall_E, stall_M}), 32'(e_st));
    check("flushes", 32'({flush_D, flush_E}), 32'(e_fl));
    check("fwdA", 32'(fwdA_E), RST ? 32'd0 : 32'(ref_fwd(rs1_addr_E)));
    check("fwdB", 32'(fwdB_E), RST ? 32'd0 : 32'(ref_fwd(rs2_addr_E)));
    check("stall_cnt", 32'(stall_cnt), sat(m_stall, 16));
    check("flush_cnt", 32'(flush_cnt), sat(m_flush, 16));
    check("stall_cnt4", 32'(stall_cnt4), sat(m_stall, 4));
    check("flush_cnt4", 32'(flush_cnt4), sat(m_flush, 4));
    @(posedge CLK);
    if (!RST) begin
      pending = pending ? !mem_ready : (imem_miss || dmem_miss);
      if (e_st[3]) m_stall++;
      if (br)      m_flush++;
    end
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    rs1_addr_D = 0; rs2_addr_D = 0; rs1_addr_E = 0; rs2_addr_E = 0;
    rd_E = 0; rd_M = 0; rd_W = 0;
    memRead2_E = 0; regWrite_M = 0; regWrite_W = 0; pc_src_E = 0;
    imem_miss = 0; dmem_miss = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    pending = 1'b0;
    m_stall = 0;
    m_flush = 0;
    do_reset();
    step();

    // D-miss held four frozen cycles, released by mem_ready
    dmem_miss = 1;
    repeat (4) step();
    mem_ready = 1;
    step();
    clear_inputs();
    step();
    check("dmiss_total", 32'(stall_cnt), 32'd4);

    // Load-use, then same with rd_E = x0
    memRead2_E = 1; rd_E = 5; rs2_addr_D = 5;
    step();
    rd_E = 0;
    step();
    check("loaduse_total", 32'(stall_cnt), 32'd5);
    clear_inputs();

    // Forwarding M beats W, then W alone
    rd_M = 7; rd_W = 7; regWrite_M = 1; regWrite_W = 1; rs1_addr_E = 7; rs2_addr_E = 7;
    step();
    regWrite_M = 0;
    step();
    clear_inputs();

    // Branch beats load-use
    pc_src_E = 1; memRead2_E = 1; rd_E = 3; rs1_addr_D = 3;
    step();
    check("branch_total", 32'(flush_cnt), 32'd1);
    clear_inputs();

    // Simultaneous misses: D served first, I-miss freezes again afterwards
    imem_miss = 1; dmem_miss = 1;
    repeat (2) step();
    mem_ready = 1;
    step();
    mem_ready = 0; dmem_miss = 0;
    repeat (3) step();
    mem_ready = 1;
    step();
    clear_inputs();
    step();

    // Reset mid-miss; a stale mem_ready afterwards must not disturb anything
    dmem_miss = 1;
    repeat (2) step();
    RST = 1;
    step();
    RST = 0; dmem_miss = 0; mem_ready = 1;
    step();
    clear_inputs();
    step();

    // Saturation of the narrow counter
    do_reset();
    dmem_miss = 1;
    repeat (20) step();
    check("sat4", 32'(stall_cnt4), 32'd15);
    mem_ready = 1;
    step();
    clear_inputs();
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      RST        = ($urandom_range(0, 149) == 0);
      rs1_addr_D = 5'($urandom_range(0, 3));
      rs2_addr_D = 5'($urandom_range(0, 3));
      rs1_addr_E = 5'($urandom_range(0, 3));
      rs2_addr_E = 5'($urandom_range(0, 3));
      rd_E       = 5'($urandom_range(0, 3));
      rd_M       = 5'($urandom_range(0, 3));
      rd_W       = 5'($urandom_range(0, 3));
      memRead2_E = ($urandom_range(0, 2) == 0);
      regWrite_M = 1'($urandom_range(0, 1));
      regWrite_W = 1'($urandom_range(0, 1));
      pc_src_E   = ($urandom_range(0, 5) == 0);
      imem_miss  = ($urandom_range(0, 7) == 0);
      dmem_miss  = ($urandom_range(0, 9) == 0);
      mem_ready  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
